// File: rtl/fixed_divide.sv
// Sequential signed fixed-point divider: ans = (a << fractional_size) / b, one quotient bit per clock.
// Optional build macro FIXED_DIVIDE_ROUND_EN selects round-half-away-from-zero instead of truncation.
module fixed_divide #(
  parameter int unsigned fractional_size = 12,
  parameter int unsigned operand_size    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [operand_size-1:0] in_a,
  input  logic [operand_size-1:0] in_b,
  output logic                    ou_valid,
  input  logic                    ou_ready,
  output logic [operand_size-1:0] ou_ans,
  output logic                    ou_overflow,
  output logic                    ou_div_zero
);

  localparam int unsigned n_bits     = operand_size;
  localparam int unsigned iter_count = operand_size + fractional_size;
  localparam int unsigned cnt_w      = $clog2(iter_count + 1);

  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(iter_count - 1);
  localparam logic [n_bits-1:0] ans_max = {1'b0, {(n_bits-1){1'b1}}};
  localparam logic [n_bits-1:0] ans_min = {1'b1, {(n_bits-1){1'b0}}};
  // Magnitude limits in the (iter_count+1)-bit quotient domain.
  localparam logic [iter_count:0] neg_lim =
    {{(iter_count-n_bits+1){1'b0}}, 1'b1, {(n_bits-1){1'b0}}};
  localparam logic [iter_count:0] pos_lim = neg_lim - 1'b1;

  typedef enum logic [1:0] {StIdle, StCalc, StFinal, StDone} state_e;

  state_e                state_q, state_d;
  logic                  sign_q, sign_d;
  logic [n_bits-1:0]     absb_q, absb_d;
  logic [n_bits:0]       rem_q, rem_d;
  // Holds the dividend bits on entry; quotient bits shift in from the bottom.
  logic [iter_count-1:0] div_q, div_d;
  logic [cnt_w-1:0]      cnt_q, cnt_d;
  logic [n_bits-1:0]     ans_q, ans_d;
  logic                  ovf_q, ovf_d;
  logic                  dz_q, dz_d;

  logic [n_bits-1:0]     abs_a, abs_b;
  logic [n_bits+1:0]     rem_shift;
  logic                  rem_ge;
  logic [iter_count:0]   q_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sign_q  <= 1'b0;
      absb_q  <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      ans_q   <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      absb_q  <= absb_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      ans_q   <= ans_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    absb_d    = absb_q;
    rem_d     = rem_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    ans_d     = ans_q;
    ovf_d     = ovf_q;
    dz_d      = dz_q;

    abs_a     = in_a[n_bits-1] ? (~in_a + 1'b1) : in_a;
    abs_b     = in_b[n_bits-1] ? (~in_b + 1'b1) : in_b;
    rem_shift = {rem_q, div_q[iter_count-1]};
    rem_ge    = (rem_shift >= {2'b00, absb_q});
    q_ext     = {1'b0, div_q};

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          sign_d = in_a[n_bits-1] ^ in_b[n_bits-1];
          absb_d = abs_b;
          rem_d  = '0;
          div_d  = {abs_a, {fractional_size{1'b0}}};
          cnt_d  = '0;
          if (in_b == '0) begin
            ans_d   = in_a[n_bits-1] ? ans_min : ans_max;
            dz_d    = 1'b1;
            ovf_d   = 1'b0;
            state_d = StDone;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        rem_d = rem_ge ? (rem_shift[n_bits:0] - {1'b0, absb_q}) : rem_shift[n_bits:0];
        div_d = {div_q[iter_count-2:0], rem_ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == cnt_last) begin
          state_d = StFinal;
        end
      end
      StFinal: begin
`ifdef FIXED_DIVIDE_ROUND_EN
        if ({rem_q, 1'b0} >= {2'b00, absb_q}) begin
          q_ext = q_ext + 1'b1;
        end
`endif
        dz_d = 1'b0;
        if (sign_q) begin
          if (q_ext > neg_lim) begin
            ans_d = ans_min;
            ovf_d = 1'b1;
          end else begin
            ans_d = -q_ext[n_bits-1:0];
            ovf_d = 1'b0;
          end
        end else begin
          if (q_ext > pos_lim) begin
            ans_d = ans_max;
            ovf_d = 1'b1;
          end else begin
            ans_d = q_ext[n_bits-1:0];
            ovf_d = 1'b0;
          end
        end
        state_d = StDone;
      end
      StDone: begin
        if (ou_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign in_ready    = (state_q == StIdle);
  assign ou_valid    = (state_q == StDone);
  assign ou_ans      = ans_q;
  assign ou_overflow = ovf_q;
  assign ou_div_zero = dz_q;

endmodule

// File: tb/tb_fixed_divide.sv
// Directed-vector bench for fixed_divide (default Q20.12, 32-bit operands).
module tb_fixed_divide;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        ou_valid;
  logic        ou_ready;
  logic [31:0] ou_ans;
  logic        ou_overflow;
  logic        ou_div_zero;

  int n_cmp  = 0;
  int n_fail = 0;

  fixed_divide dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .ou_valid   (ou_valid),
    .ou_ready   (ou_ready),
    .ou_ans     (ou_ans),
    .ou_overflow(ou_overflow),
    .ou_div_zero(ou_div_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one operand pair for a single cycle and waits for ou_valid.
  // lat is the cycle index (accept = 0) at which ou_valid was first seen, -1 on timeout.
  task automatic issue_and_wait(input logic [31:0] a, input logic [31:0] b, output int lat);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat      = 1;
    while (!ou_valid && lat < 200) begin
      tick();
      lat++;
    end
    if (!ou_valid) lat = -1;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    ou_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
    n_cmp++;
    if (ou_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_ou_valid got=%b want=0", ou_valid);
    end
    n_cmp++;
    if ({ou_ans, ou_overflow, ou_div_zero} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got ans=%h ovf=%b dz=%b want 0/0/0",
               ou_ans, ou_overflow, ou_div_zero);
    end
  endtask

  task automatic test_divide();
    logic [31:0] va[11], vb[11], vans[11];
    logic        vovf[11], vdz[11];
    int          vlat[11];
    int          lat;
    va[0]  = 32'd6144;      vb[0]  = 32'd2048; vans[0]  = 32'd12288;
    va[1]  = -32'sd6144;    vb[1]  = 32'd2048; vans[1]  = -32'sd12288;
    va[2]  = -32'sd6144;    vb[2]  = -32'sd2048; vans[2] = 32'd12288;
    va[3]  = 32'd6144;      vb[3]  = -32'sd2048; vans[3] = -32'sd12288;
    va[4]  = 32'd4096;      vb[4]  = 32'd0;    vans[4]  = 32'h7FFF_FFFF;
    va[5]  = -32'sd4096;    vb[5]  = 32'd0;    vans[5]  = 32'h8000_0000;
    va[6]  = 32'h7FFF_FFFF; vb[6]  = 32'd1;    vans[6]  = 32'h7FFF_FFFF;
    va[7]  = 32'h8000_0000; vb[7]  = 32'd4096; vans[7]  = 32'h8000_0000;
    va[8]  = 32'h8000_0000; vb[8]  = 32'd1;    vans[8]  = 32'h8000_0000;
`ifdef FIXED_DIVIDE_ROUND_EN
    va[9]  = 32'd2;         vb[9]  = 32'd3;    vans[9]  = 32'd2731;
`else
    va[9]  = 32'd2;         vb[9]  = 32'd3;    vans[9]  = 32'd2730;
`endif
    va[10] = 32'd1;         vb[10] = 32'd3;    vans[10] = 32'd1365;
    for (int i = 0; i < 11; i++) begin
      vovf[i] = (i == 6) || (i == 8);
      vdz[i]  = (i == 4) || (i == 5);
      vlat[i] = vdz[i] ? 1 : 46;
    end
    ou_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_fail++; $display("FAIL div%0d_in_ready got=%b want=1", i, in_ready);
      end
      issue_and_wait(va[i], vb[i], lat);
      n_cmp++;
      if (lat !== vlat[i]) begin
        n_fail++; $display("FAIL div%0d_latency got=%0d want=%0d", i, lat, vlat[i]);
      end
      n_cmp++;
      if (ou_ans !== vans[i]) begin
        n_fail++; $display("FAIL div%0d_ans got=%h want=%h", i, ou_ans, vans[i]);
      end
      n_cmp++;
      if (ou_overflow !== vovf[i]) begin
        n_fail++; $display("FAIL div%0d_overflow got=%b want=%b", i, ou_overflow, vovf[i]);
      end
      n_cmp++;
      if (ou_div_zero !== vdz[i]) begin
        n_fail++; $display("FAIL div%0d_div_zero got=%b want=%b", i, ou_div_zero, vdz[i]);
      end
      tick();
      n_cmp++;
      if ({ou_valid, in_ready} !== 2'b01) begin
        n_fail++;
        $display("FAIL div%0d_release got valid=%b ready=%b want 0/1", i, ou_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    ou_ready = 1'b0;
    issue_and_wait(32'd6144, 32'd2048, lat);
    n_cmp++;
    if (lat !== 46) begin
      n_fail++; $display("FAIL bp_latency got=%0d want=46", lat);
    end
    for (int k = 0; k < 5; k++) begin
      in_a     = 32'd4096;
      in_b     = 32'd0;
      in_valid = 1'b1;
      tick();
      n_cmp++;
      if ({ou_valid, in_ready, ou_ans, ou_overflow, ou_div_zero} !== {2'b10, 32'd12288, 2'b00}) begin
        n_fail++;
        $display("FAIL bp_hold%0d got valid=%b ready=%b ans=%h ovf=%b dz=%b want 1/0/00003000/0/0",
                 k, ou_valid, in_ready, ou_ans, ou_overflow, ou_div_zero);
      end
    end
    in_valid = 1'b0;
    ou_ready = 1'b1;
    tick();
    n_cmp++;
    if ({ou_valid, in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL bp_release got valid=%b ready=%b want 0/1", ou_valid, in_ready);
    end
    tick();
    n_cmp++;
    if ({ou_valid, in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL bp_no_queue got valid=%b ready=%b want 0/1", ou_valid, in_ready);
    end
  endtask

  task automatic test_mid_reset();
    int lat;
    ou_ready = 1'b1;
    in_a     = 32'd6144;
    in_b     = 32'd2048;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k < 20; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({in_ready, ou_valid, ou_ans, ou_overflow, ou_div_zero} !== {2'b10, 34'd0}) begin
      n_fail++;
      $display("FAIL midrst_state got ready=%b valid=%b ans=%h ovf=%b dz=%b want 1/0/0/0/0",
               in_ready, ou_valid, ou_ans, ou_overflow, ou_div_zero);
    end
    issue_and_wait(32'd6144, 32'd2048, lat);
    n_cmp++;
    if (lat !== 46) begin
      n_fail++; $display("FAIL midrst_latency got=%0d want=46", lat);
    end
    n_cmp++;
    if ({ou_ans, ou_overflow, ou_div_zero} !== {32'd12288, 2'b00}) begin
      n_fail++;
      $display("FAIL midrst_result got ans=%h ovf=%b dz=%b want 00003000/0/0",
               ou_ans, ou_overflow, ou_div_zero);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_divide();
    test_backpressure();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
